// File: rtl/tick_scheduler.sv
// NUM_CH independent programmable tick dividers that share one valid/ready period-config port.
// Defining TICKSCHED_SQUARE_EN adds a per-channel sq_out square wave that toggles on every tick.
module tick_scheduler #(
    parameter int          NUM_CH         = 3,
    parameter int          CNT_W          = 16,
    parameter int unsigned DEFAULT_PERIOD = 1,
    localparam int         CH_W           = $clog2(NUM_CH) + 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    output logic [NUM_CH-1:0] tick,
`ifdef TICKSCHED_SQUARE_EN
    output logic [NUM_CH-1:0] sq_out,
`endif
    output logic [NUM_CH-1:0] pending
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] act_q, act_d;
    logic [NUM_CH-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0]            pending_q, pending_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic [NUM_CH-1:0]            cfg_hit;
    logic [NUM_CH-1:0]            wrap;

    // An out-of-range cfg_ch matches no channel, so it is always ready and writes nothing.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cfg_ready = 1'b1;
        cfg_hit   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_ch == CH_W'(c)) begin
                cfg_ready  = ~pending_q[c];
                cfg_hit[c] = cfg_valid & ~pending_q[c];
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        act_d     = act_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        tick_d    = '0;
        wrap      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            // ">=" lets a period lowered below the running count wrap on the next edge.
            wrap[c] = en[c] & (cnt_q[c] >= act_q[c]);
            if (!en[c] || wrap[c]) begin
                cnt_d[c] = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
            tick_d[c] = wrap[c];
            if ((!en[c] || wrap[c]) && pending_q[c]) begin
                act_d[c]     = pend_q[c];
                pending_d[c] = 1'b0;
            end
            // A write is accepted only while nothing is pending, so it never collides with the clear.
            if (cfg_hit[c]) begin
                pend_d[c]    = cfg_period;
                pending_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            act_q     <= {NUM_CH{DEF_P}};
            pend_q    <= '0;
            pending_q <= '0;
            tick_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
        end
    end

    assign tick    = tick_q;
    assign pending = pending_q;

`ifdef TICKSCHED_SQUARE_EN
    logic [NUM_CH-1:0] sq_q, sq_d;

    assign sq_d = sq_q ^ tick_d;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sq_q <= '1;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq_out = sq_q;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: a cycle model pushes the expected outputs to a queue on each edge,
// and the bench pops and compares them one step later, next to directed checks taken from the scenarios.
module tb_tick_scheduler;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int CH_W   = $clog2(NUM_CH) + 1;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;
`ifdef TICKSCHED_SQUARE_EN
    logic [NUM_CH-1:0] sq_out;
`endif

    tick_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(1)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .tick       (tick),
`ifdef TICKSCHED_SQUARE_EN
        .sq_out     (sq_out),
`endif
        .pending    (pending)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] pending;
        logic [NUM_CH-1:0] sq;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic last_ready;

    // Cycle model state
    int m_cnt[NUM_CH];
    int m_act[NUM_CH];
    int m_pend[NUM_CH];
    bit m_pending[NUM_CH];
    bit m_tick[NUM_CH];
    bit m_sq[NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_act[c] = 1; m_pend[c] = 0;
            m_pending[c] = 0; m_tick[c] = 0; m_sq[c] = 1;
        end
    endtask

    function automatic bit model_ready();
        if (int'(cfg_ch) >= NUM_CH) return 1'b1;
        return !m_pending[int'(cfg_ch)];
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            bit at_end;
            bit hit;
            at_end = en[c] && (m_cnt[c] >= m_act[c]);
            hit    = cfg_valid && (int'(cfg_ch) == c) && !m_pending[c];
            m_tick[c] = at_end;
            m_cnt[c]  = (en[c] && !at_end) ? m_cnt[c] + 1 : 0;
            if ((!en[c] || at_end) && m_pending[c]) begin
                m_act[c]     = m_pend[c];
                m_pending[c] = 0;
            end
            if (hit) begin
                m_pend[c]    = int'(cfg_period);
                m_pending[c] = 1;
            end
            if (at_end) m_sq[c] = !m_sq[c];
        end
    endtask

    function automatic logic [NUM_CH-1:0] pack(input bit v[NUM_CH]);
        logic [NUM_CH-1:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c] = v[c];
        return r;
    endfunction

    // One clock step: check ready, predict the edge, then compare the registered outputs after it.
    task automatic cycle();
        exp_t e;
        #1;
        last_ready = cfg_ready;
        check("cfg_ready", {31'b0, cfg_ready}, {31'b0, model_ready()});
        model_edge();
        e.tick    = pack(m_tick);
        e.pending = pack(m_pending);
        e.sq      = pack(m_sq);
        exp_q.push_back(e);
        @(posedge clk_in);
        #1;
        e = exp_q.pop_front();
        check("tick", 32'(tick), 32'(e.tick));
        check("pending", 32'(pending), 32'(e.pending));
`ifdef TICKSCHED_SQUARE_EN
        check("sq_out", 32'(sq_out), 32'(e.sq));
`endif
    endtask

    // Holds the request until it is accepted; held counts the cycles it was refused.
    task automatic cfg_write(input int ch, input int p, output int held);
        held       = 0;
        cfg_valid  = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_period = CNT_W'(p);
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (last_ready) break;
            held++;
        end
        cfg_valid = 1'b0;
        check("cfg_accepted", {31'b0, last_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int held;
        int last_t;
        int ngap;
        int highs;
        logic s[7];

        rst_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0;
        model_reset();
        #1;
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_ready", {31'b0, cfg_ready}, 32'd1);
`ifdef TICKSCHED_SQUARE_EN
        check("rst_sq", 32'(sq_out), 32'h7);
`endif
        @(posedge clk_in); @(posedge clk_in); #1;
        rst_n = 1'b1;

        // 1: default period 1 on ch0 ticks on even edges only
        en = 3'b001;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            check("t1_tick0", {31'b0, tick[0]}, {31'b0, (k % 2 == 0)});
            check("t1_tick21", 32'(tick[2:1]), 32'd0);
        end

        // 2: P=4 stays pending until the next wrap, then ticks are 5 cycles apart
        cfg_write(0, 4, held);
        check("t2_pending0", {31'b0, pending[0]}, 32'd1);
        #1;
        check("t2_ready_low", {31'b0, cfg_ready}, 32'd0);
        last_t = -1; ngap = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (tick[0]) begin
                if (last_t >= 0 && ngap < 2) begin
                    check("t2_gap", 32'(k - last_t), 32'd5);
                    ngap++;
                end
                last_t = k;
            end
        end
        check("t2_gap_count", 32'(ngap), 32'd2);
        check("t2_pending_clr", {31'b0, pending[0]}, 32'd0);

        // 3: ch1 is accepted inside the ch0 window; a second ch0 write is held off until the wrap
        en = 3'b011;
        cfg_write(0, 2, held);
        check("t3_pending0", {31'b0, pending[0]}, 32'd1);
        cfg_write(1, 3, held);
        check("t3_ch1_held", 32'(held), 32'd0);
        check("t3_pending1", {31'b0, pending[1]}, 32'd1);
        cfg_write(0, 6, held);
        check("t3_ch0_held", {31'b0, held > 0}, 32'd1);
        check("t3_pending0b", {31'b0, pending[0]}, 32'd1);
        for (int k = 0; k < 8; k++) cycle();

        // 4: P=0 on ch2 holds tick high; an out-of-range channel is accepted and ignored
        cfg_write(2, 0, held);
        cycle();
        en = 3'b111;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t4_tick2", {31'b0, tick[2]}, 32'd1);
        end
        cfg_valid = 1'b1; cfg_ch = 3'd7; cfg_period = 16'd5;
        #1;
        check("t4_ready_ch7", {31'b0, cfg_ready}, 32'd1);
        cycle();
        cfg_valid = 1'b0; cfg_ch = '0;
        for (int k = 0; k < 3; k++) cycle();

        // 5: reset mid-period with a pending update
        cfg_write(0, 9, held);
        check("t5_pending0", {31'b0, pending[0]}, 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_rst_tick", 32'(tick), 32'd0);
        check("t5_rst_pending", 32'(pending), 32'd0);
`ifdef TICKSCHED_SQUARE_EN
        check("t5_rst_sq", 32'(sq_out), 32'h7);
`endif
        cycle();
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check("t5_tick0", {31'b0, tick[0]}, {31'b0, (k % 2 == 0)});
            check("t5_tick2", {31'b0, tick[2]}, {31'b0, (k % 2 == 0)});
        end

`ifdef TICKSCHED_SQUARE_EN
        // 6: P=2 gives a 6-cycle, 50% square wave on sq_out[0]
        cfg_write(0, 2, held);
        for (int k = 0; k < 6; k++) cycle();
        highs = 0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            s[k] = sq_out[0];
            if (k < 6 && sq_out[0]) highs++;
        end
        check("t6_duty", 32'(highs), 32'd3);
        check("t6_half", {31'b0, s[0] ^ s[3]}, 32'd1);
        check("t6_period", {31'b0, s[0] ^ s[6]}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
